emergency_request_conditioner: RTL and testbench
================================================

# emergency_request_conditioner

Upstream stage of the intersection traffic controller: turns the raw left/right emergency-vehicle sensor lines into clean single-cycle `emergency_left`/`emergency_right` trigger pulses that drive the controller's emergency inputs directly. Each line is synchronised, debounced and rising-edge detected. A round-robin arbiter then issues one pulse at a time, followed by a cooldown window. Runs in the controller's `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 3, consecutive mismatching cycles before a debounced level changes; legal range 1..255.
- `COOLDOWN_CYCLES`, 10, cycles of enforced quiet after each issued pulse; legal range 1..255.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `sense_left_raw`  in  1  asynchronous, bouncy left emergency sensor.
- `sense_right_raw`  in  1  asynchronous, bouncy right emergency sensor.
- `emergency_left`  out  1  registered one-cycle trigger pulse to the controller's left emergency input.
- `emergency_right`  out  1  registered one-cycle trigger pulse to the controller's right emergency input.
- `busy`  out  1  high while in FIRE or COOLDOWN.
- `event_count`  out  8  number of pulses issued; saturates at 255.

## Operation
- **Sync:** two flops per channel (`s1`, `s2`); both reset to 0.
- **Debounce** (per channel; debounced level `deb` and 8-bit counter `cnt`):
  - If `s2 == deb`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Edge capture:** when `deb` goes 0->1, set that channel's `pending` on the same edge.
  - `pending` is one deep; a rise on a channel that is already pending merges silently.
  - Falling `deb` has no effect other than re-arming the next rise.
- **Arbiter FSM** (states IDLE, FIRE, COOLDOWN):
  - IDLE: if either `pending` is set, go to FIRE. Choose the channel as follows:
    - Only one pending: that channel.
    - Both pending: the channel not in `last_served`.
    - Register the matching output high for the FIRE cycle, clear that channel's `pending`, and update `last_served`.
  - FIRE: go to COOLDOWN and load `cool_cnt <= COOLDOWN_CYCLES-1`.
  - COOLDOWN: decrement `cool_cnt`; when `cool_cnt == 0`, go to IDLE. New rises still set `pending` during COOLDOWN.
- `emergency_left` and `emergency_right` are never high in the same cycle.
- `event_count` increments on entry to FIRE and holds at 255.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - All `s1`/`s2`/`deb`/`cnt`/`pending`/`cool_cnt` 0.
  - `last_served` = right, so left wins the first tie.
- Latency: raw rises and is held before edge k, with the arbiter in IDLE:
  - `s2`=1 after edge k+1.
  - `deb`=1 after edge k+1+D.
  - Pulse high for exactly one cycle after edge k+2+D (D = `DEBOUNCE_CYCLES`; default: pulse after edge k+5).
- Glitches: raw pulses shorter than D cycles after sync produce no `deb` change.
- Pulse spacing: minimum COOLDOWN_CYCLES+2 edges between successive pulse starts (one FIRE cycle, COOLDOWN_CYCLES COOLDOWN cycles, one IDLE cycle).
- Simultaneous debounced rises on both channels in the same cycle:
  - Two pulses, separated by COOLDOWN_CYCLES+2.
  - Order follows `last_served`.
- `busy` rises with the pulse and falls on the edge entering IDLE.
- Reset mid-operation: every register clears asynchronously.
  - Any pulse or `busy` drops immediately.
  - Pending requests and `event_count` are lost.

## Configuration
- `EMERG_EVENT_COUNT_EN`:
  - Defined: the 8-bit saturating `event_count` register is built as described above.
  - Undefined: no counter register; `event_count` is tied to 8'd0. All other behaviour is identical.

## Test plan
- Reset, `sense_left_raw` held high from before edge 0 (defaults) -> `emergency_left`=1 only in the cycle after edge 5; `busy` high for 11 cycles; `event_count`=1.
- `sense_right_raw` 2-cycle glitch, then low -> no pulse, `busy` stays 0, `event_count` stays 0.
- Both raw lines rise together after reset -> left pulse after edge 5 and right pulse after edge 17; never both high at once; `event_count`=2.
- Left re-rises (after clean release) during COOLDOWN -> second left pulse exactly 12 cycles after the first.
- `rst` asserted mid-COOLDOWN with right pending -> outputs 0 immediately; no pulse after `rst` release until a new debounced rise.
- 300 spaced left events (with `EMERG_EVENT_COUNT_EN` defined) -> `event_count` saturates at 255; without the macro, `event_count` reads 0 throughout.

Source files
------------

// File: rtl/emergency_request_conditioner.sv
// Emergency sensor conditioner: sync, debounce, edge capture, round-robin pulse.
// EMERG_EVENT_COUNT_EN builds the saturating event_count register.
module emergency_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned COOLDOWN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_left_raw,
  input  logic       sense_right_raw,
  output logic       emergency_left,
  output logic       emergency_right,
  output logic       busy,
  output logic [7:0] event_count
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOLDOWN
  } state_t;

  // channel index 0 = left, 1 = right
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] deb;
  logic [1:0] pending;
  logic [1:0] rise;
  logic [1:0] serve;
  logic [7:0] cnt [2];
  logic [7:0] cool_q;
  logic [7:0] cool_d;
  logic       last_served;
  state_t     state_q;
  state_t     state_d;

  // two-flop synchroniser and per-channel debounce counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= {sense_right_raw, sense_left_raw};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // debounced level about to go 0->1 on this edge
  always_comb begin
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      rise[i] = s2[i] & ~deb[i] & (cnt[i] == DEB_LAST);
    end
  end

  // one-deep request latch; serving a channel wins over a merging rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (serve[i]) pending[i] <= 1'b0;
        else if (rise[i]) pending[i] <= 1'b1;
      end
    end
  end

  // arbiter next state, channel choice and cooldown count
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    serve   = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d = FIRE;
          if (&pending) serve = last_served ? 2'b01 : 2'b10;
          else serve = pending;
        end
      end
      FIRE: begin
        state_d = COOLDOWN;
        cool_d  = COOL_LAST;
      end
      COOLDOWN: begin
        if (cool_q == 8'd0) state_d = IDLE;
        else cool_d = cool_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // arbiter state, registered pulses and round-robin memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cool_q          <= '0;
      last_served     <= 1'b1;
      emergency_left  <= 1'b0;
      emergency_right <= 1'b0;
    end else begin
      state_q         <= state_d;
      cool_q          <= cool_d;
      emergency_left  <= serve[0];
      emergency_right <= serve[1];
      if (|serve) last_served <= serve[1];
    end
  end

  assign busy = (state_q != IDLE);

`ifdef EMERG_EVENT_COUNT_EN
  logic [7:0] evt_q;

  // saturating count of issued pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_q <= '0;
    else if (|serve && evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
  end

  assign event_count = evt_q;
`else
  assign event_count = 8'd0;
`endif

endmodule

// File: tb/tb_emergency_request_conditioner.sv
// Bench for emergency_request_conditioner: reference model plus scoreboard.
// Directed scenarios followed by randomized sensor activity.
module tb_emergency_request_conditioner;

  localparam int D = 3;
  localparam int C = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sense_left_raw = 1'b0;
  logic       sense_right_raw = 1'b0;
  logic       emergency_left;
  logic       emergency_right;
  logic       busy;
  logic [7:0] event_count;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  typedef struct {
    int cyc;
    bit ch;
  } exp_t;

  exp_t q[$];

  emergency_request_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .COOLDOWN_CYCLES(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sense_left_raw(sense_left_raw),
    .sense_right_raw(sense_right_raw),
    .emergency_left(emergency_left),
    .emergency_right(emergency_right),
    .busy(busy),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: sensor history decides debounced level,
  // arbiter may fire once C+2 edges have passed since the last pulse
  int cyc = 0;
  int next_ok = 0;
  int fire_cyc = 0;
  bit fired = 0;
  bit busy_m = 0;
  int cnt_m = 0;
  bit s1m[2];
  bit s2m[2];
  bit debm[2];
  bit pendm[2];
  bit last_m = 1;
  logic [15:0] hv[2];

  always @(posedge clk or posedge rst) begin
    bit rise_m[2];
    bit go;
    bit ch;
    bit all;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        s1m[i] = 0; s2m[i] = 0; debm[i] = 0;
        pendm[i] = 0; hv[i] = '0;
      end
      last_m = 1; next_ok = 0; fired = 0;
      busy_m = 0; cnt_m = 0;
      q.delete();
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        hv[i] = {hv[i][14:0], s2m[i]};
        all = 1;
        for (int j = 0; j < D; j++) if (hv[i][j] == debm[i]) all = 0;
        rise_m[i] = 0;
        if (all) begin
          debm[i] = !debm[i];
          rise_m[i] = debm[i];
          hv[i] = {16{debm[i]}};
        end
      end
      go = (cyc >= next_ok) && (pendm[0] || pendm[1]);
      ch = (pendm[0] && pendm[1]) ? !last_m : pendm[1];
      for (int i = 0; i < 2; i++) if (rise_m[i]) pendm[i] = 1;
      if (go) begin
        pendm[ch] = 0;
        last_m = ch;
        q.push_back('{cyc: cyc, ch: ch});
        next_ok = cyc + C + 2;
        fire_cyc = cyc;
        fired = 1;
`ifdef EMERG_EVENT_COUNT_EN
        if (cnt_m < 255) cnt_m++;
`endif
      end
      busy_m = fired && (cyc - fire_cyc <= C);
      s2m = s1m;
      s1m[0] = sense_left_raw;
      s1m[1] = sense_right_raw;
    end
  end

  // monitor: compare every cycle, pop scoreboard on each pulse
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    check("busy", busy, busy_m);
    check("event_count", int'(event_count), cnt_m);
    check("exclusive", emergency_left & emergency_right, 0);
    if (emergency_left || emergency_right) begin
      npulse++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got l=%0b r=%0b expected none at %0t",
                 emergency_left, emergency_right, $time);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ch != emergency_right) begin
          errors++;
          $display("FAIL pulse got cyc=%0d ch=%0b expected cyc=%0d ch=%0b",
                   cyc, emergency_right, e.cyc, e.ch);
        end
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse got none expected cyc=%0d ch=%0b",
               e.cyc, e.ch);
    end
  end

  task automatic hold(input bit l, input bit r, input int n);
    sense_left_raw = l;
    sense_right_raw = r;
    repeat (n) @(negedge clk);
  endtask

  // reset with raw lines already at l/r; next posedge is edge 0
  task automatic start(input bit l, input bit r);
    @(negedge clk);
    rst = 1'b1;
    sense_left_raw = l;
    sense_right_raw = r;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic watch(input int n, input int la, input int lb,
                       input int ra, output int bcnt);
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("left_e%0d", i), emergency_left,
            int'(i == la || i == lb));
      check($sformatf("right_e%0d", i), emergency_right, int'(i == ra));
      bcnt += int'(busy);
    end
  endtask

  int bc;
  int n0;
  int ev_exp;

  initial begin
`ifdef EMERG_EVENT_COUNT_EN
    ev_exp = 1;
`else
    ev_exp = 0;
`endif
    repeat (2) @(negedge clk);
    check("reset_left", emergency_left, 0);
    check("reset_right", emergency_right, 0);
    check("reset_busy", busy, 0);
    check("reset_count", int'(event_count), 0);

    // left held from before edge 0
    start(1, 0);
    watch(20, 5, -1, -1, bc);
    check("busy_cycles", bc, 11);
    check("count_one", int'(event_count), ev_exp);
    hold(0, 0, 10);

    // short right glitch
    start(0, 0);
    hold(0, 0, 4);
    n0 = npulse;
    hold(0, 1, 2);
    hold(0, 0, 20);
    check("glitch_pulses", npulse, n0);
    check("glitch_busy", busy, 0);
    check("glitch_count", int'(event_count), 0);

    // both lines together
    start(1, 1);
    watch(26, 5, -1, 17, bc);
    check("both_count", int'(event_count), 2 * ev_exp);
    hold(0, 0, 10);

    // left re-rise during cooldown
    start(1, 0);
    fork
      begin
        hold(1, 0, 6);
        hold(0, 0, 4);
        hold(1, 0, 16);
      end
      watch(26, 5, 17, -1, bc);
    join
    hold(0, 0, 20);

    // reset in cooldown while right pending
    start(1, 1);
    hold(1, 1, 8);
    check("pre_rst_busy", busy, 1);
    sense_left_raw = 0;
    sense_right_raw = 0;
    rst = 1'b1;
    #1;
    check("rst_left", emergency_left, 0);
    check("rst_right", emergency_right, 0);
    check("rst_busy", busy, 0);
    check("rst_count", int'(event_count), 0);
    hold(0, 0, 2);
    rst = 1'b0;
    n0 = npulse;
    hold(0, 0, 30);
    check("no_pulse_after_rst", npulse, n0);
    hold(0, 1, 6);
    hold(0, 0, 20);
    check("new_rise_pulse", npulse, n0 + 1);

    // saturation with spaced left events
    start(0, 0);
    repeat (300) begin
      hold(1, 0, 6);
      hold(0, 0, 8);
    end
    hold(0, 0, 20);
`ifdef EMERG_EVENT_COUNT_EN
    check("saturated", int'(event_count), 255);
`else
    check("no_counter", int'(event_count), 0);
`endif

    // randomized activity
    start(0, 0);
    repeat (300) begin
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(1, 12));
    end
    hold(0, 0, 40);
    check("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
